sweep_ctrl: RTL and testbench
=============================

// Module: sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer for the sample-rate tick generator. Steps the output
//  frequency from f_start to f_stop in f_inc increments, holding each point for a
//  programmed number of sample ticks. For each point it computes the half-period
//  count with a serial divider and publishes the result over a valid/ack handshake.
// PARAMETERS
//  CLK_HZ       100_000_000  system clock frequency, Hz
//  F_MAX        2828         highest legal frequency, Hz
//  SPC_LOG2     13           log2 of samples per waveform cycle (8192)
//  DWELL_W      16           width of the dwell counter
// PORTS
//  CLOCK        in   1        system clock, rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  start        in   1        1-cycle pulse that begins a sweep; sampled only in IDLE
//  abort        in   1        level; returns the block to IDLE from any state
//  f_start      in   12       first frequency, Hz; latched on start
//  f_stop       in   12       last frequency, Hz; latched on start
//  f_inc        in   12       frequency increment, Hz; latched on start
//  step         in   8        phase step; latched on start
//  dwell        in   DWELL_W  sample ticks per point; 0 is treated as 1
//  tick_in      in   1        START_CLOCK from the tick generator, same clock domain
//  cfg_valid    out  1        cfg_freq and cfg_half are valid
//  cfg_ack      in   1        consumer accepts the config
//  cfg_freq     out  12       current frequency point, Hz
//  cfg_half     out  32       half-period count: floor(CLK_HZ*step/(freq<<SPC_LOG2))>>1
//  busy         out  1        high in every state except IDLE
//  done         out  1        1-cycle pulse when the sweep completes normally
//  err          out  1        1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset: all outputs 0 and state=IDLE. reset_n deasserting mid-divide discards the
//   divide and leaves no partial outputs.
//  States and transitions:
//   IDLE -> CHECK on start.
//   CHECK (1 cycle): illegal if f_start==0, f_inc==0, f_start>f_stop, or f_stop>F_MAX.
//    Illegal: err=1 for 1 cycle -> IDLE. Legal: cur=f_start -> DIVIDE.
//   DIVIDE: serial restoring divide. Dividend 36 bits = CLK_HZ*step. Divisor 25 bits =
//    cur<<SPC_LOG2. Fixed 36 cycles, one quotient bit per cycle.
//    Quotient > 2^32-1 saturates to 32'hFFFF_FFFF before the >>1. Then -> PUBLISH.
//   PUBLISH: cfg_valid=1. cfg_freq and cfg_half are held stable until cfg_valid&cfg_ack.
//    cfg_valid drops in the cycle after the handshake -> DWELL.
//    If ack is already high, the handshake completes in the first PUBLISH cycle.
//   DWELL: count tick_in rising edges (registered edge detect; the first edge counts).
//    Leave when count == max(dwell,1) -> NEXT.
//   NEXT (1 cycle): nxt = cur + f_inc, computed at 13 bits.
//    If nxt > f_stop: done=1 -> IDLE.
//    Otherwise: cur=nxt -> DIVIDE.
//    Overshoot is never published: 100..125 step 10 gives 100, 110, 120.
//  abort: takes priority over every transition. Next state is IDLE.
//   cfg_valid, busy=0; no done or err pulse. cfg_freq/cfg_half keep their last values.
//  start while busy: ignored. start and abort in the same IDLE cycle: abort wins.
//  A tick_in edge that lands in the same cycle as the DWELL entry is counted.
//  Edges outside DWELL are ignored.
//  Latency from start to the first cfg_valid: 1 (CHECK) + 36 (DIVIDE) + 1 = 38 cycles.
// STRUCTURE
//  Shared package/include sig_gen_defs: CLK_HZ, F_MAX, SPC_LOG2 constants;
//   state encodings (IDLE, CHECK, DIVIDE, PUBLISH, DWELL, NEXT).
//  One sub-module: serial_div (36/25-bit restoring divider).
//   Ports: CLOCK, reset_n, go, dividend, divisor, quotient, rdy. Fixed 36-cycle latency.
//  The FSM, dwell counter, tick edge detect, and saturation logic live in sweep_ctrl.
// TESTING
//  1. f_start=f_stop=1000, inc=1, step=1, dwell=2, ack tied 1:
//     one cfg: freq=1000, half=6 (100e6/8192000=12); done after 2 tick edges.
//  2. f_start=100, f_stop=130, inc=10, step=8, dwell=1:
//     cfg_freq 100,110,120,130; cfg_half(100)=488; exactly 4 handshakes, then done.
//  3. f_start=100, f_stop=125, inc=10 -> points 100,110,120 only; done after 120.
//  4. f_stop=3000, or f_inc=0, or f_start=200>f_stop=100 -> err pulse in cycle 2;
//     busy stays 0; no cfg_valid.
//  5. cfg_ack held 0 for 10 cycles -> cfg_valid, cfg_freq, cfg_half stable all 10 cycles;
//     one transfer on ack.
//  6. abort mid-DWELL, and reset_n low mid-DIVIDE -> IDLE next cycle; no done; busy=0.
//     A fresh start afterwards produces a correct first cfg at 38 cycles.

Source files
------------

// File: rtl/sig_gen_defs.sv
// Shared constants and state encoding for the sweep sequencer and its divider.
package sig_gen_defs;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned F_MAX     = 2828;
  localparam int unsigned SPC_LOG2  = 13;
  localparam int unsigned DVD_W     = 36;
  localparam int unsigned DVS_W     = 25;
  localparam int unsigned DIV_STEPS = 36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIVIDE,
    ST_PUBLISH,
    ST_DWELL,
    ST_NEXT
  } state_e;

  function automatic logic cfg_legal(logic [11:0] fs, logic [11:0] fe, logic [11:0] fi);
    return (fs != 12'd0) && (fi != 12'd0) && (fs <= fe) && (fe <= 12'(F_MAX));
  endfunction

endpackage

// File: rtl/serial_div.sv
// Restoring divider, one quotient bit per cycle; the first bit is resolved on the go edge.
module serial_div
  import sig_gen_defs::*;
(
  input  logic             CLOCK,
  input  logic             reset_n,
  input  logic             go,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             rdy
);

  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             act_q, act_d;
  logic             rdy_q, rdy_d;

  logic [DVS_W-1:0] r_in;
  logic [DVD_W-1:0] q_in;
  logic [DVS_W-1:0] d_in;
  logic [DVS_W+DVD_W-1:0] stp;

  // quo holds the unconsumed dividend bits above and the quotient bits shifted in below
  function automatic logic [DVS_W+DVD_W-1:0] div_step(logic [DVS_W-1:0] r,
                                                      logic [DVD_W-1:0] q,
                                                      logic [DVS_W-1:0] d);
    logic [DVS_W:0] t;
    logic [DVS_W:0] diff;
    t = {r, q[DVD_W-1]};
    diff = t - {1'b0, d};
    if (t >= {1'b0, d})
      return {diff[DVS_W-1:0], q[DVD_W-2:0], 1'b1};
    else
      return {t[DVS_W-1:0], q[DVD_W-2:0], 1'b0};
  endfunction

  always_comb begin
    r_in  = go ? '0 : rem_q;
    q_in  = go ? dividend : quo_q;
    d_in  = go ? divisor : dvs_q;
    stp   = div_step(r_in, q_in, d_in);
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    act_d = act_q;
    rdy_d = 1'b0;
    if (go) begin
      rem_d = stp[DVS_W+DVD_W-1:DVD_W];
      quo_d = stp[DVD_W-1:0];
      dvs_d = divisor;
      cnt_d = 6'(DIV_STEPS - 1);
      act_d = 1'b1;
    end else if (act_q) begin
      rem_d = stp[DVS_W+DVD_W-1:DVD_W];
      quo_d = stp[DVD_W-1:0];
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        act_d = 1'b0;
        rdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      act_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign quotient = quo_q;
  assign rdy      = rdy_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps f_start..f_stop, computes each half-period count
// with serial_div, publishes it over valid/ack and dwells for a number of sample ticks.
module sweep_ctrl
  import sig_gen_defs::*;
#(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               CLOCK,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [11:0]        f_start,
  input  logic [11:0]        f_stop,
  input  logic [11:0]        f_inc,
  input  logic [7:0]         step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               tick_in,
  output logic               cfg_valid,
  input  logic               cfg_ack,
  output logic [11:0]        cfg_freq,
  output logic [31:0]        cfg_half,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [DVD_W-1:0] CLK_HZ_W = DVD_W'(CLK_HZ);

  state_e state_q, state_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic [11:0]        cfg_freq_q, cfg_freq_d;
  logic [31:0]        cfg_half_q, cfg_half_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               tick_prev_q;
  logic [11:0]        fs_q, fs_d, fe_q, fe_d, fi_q, fi_d, cur_q, cur_d;
  logic [7:0]         step_q, step_d;

  logic               tick_edge;
  logic [12:0]        nxt;
  logic [DWELL_W:0]   cnt_inc;
  logic [DWELL_W:0]   dwell_tgt;
  logic               go;
  logic [11:0]        div_freq;
  logic [DVD_W-1:0]   dividend;
  logic [DVS_W-1:0]   divisor;
  logic [DVD_W-1:0]   quotient;
  logic               div_rdy;

  function automatic logic [31:0] sat32(logic [DVD_W-1:0] q);
    return (|q[DVD_W-1:32]) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  function automatic logic [31:0] halve(logic [31:0] v);
    return {1'b0, v[31:1]};
  endfunction

  assign tick_edge = tick_in & ~tick_prev_q;
  assign nxt       = {1'b0, cur_q} + {1'b0, fi_q};
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign dwell_tgt = (dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, dwell};
  assign dividend  = CLK_HZ_W * {28'd0, step_q};
  assign divisor   = {div_freq, 13'd0};

  serial_div u_div (
    .CLOCK    (CLOCK),
    .reset_n  (reset_n),
    .go       (go),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .rdy      (div_rdy)
  );

  always_comb begin
    state_d     = state_q;
    cfg_valid_d = cfg_valid_q;
    cfg_freq_d  = cfg_freq_q;
    cfg_half_d  = cfg_half_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    fs_d        = fs_q;
    fe_d        = fe_q;
    fi_d        = fi_q;
    step_d      = step_q;
    cur_d       = cur_q;
    go          = 1'b0;
    div_freq    = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fs_d    = f_start;
          fe_d    = f_stop;
          fi_d    = f_inc;
          step_d  = step;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cfg_legal(fs_q, fe_q, fi_q)) begin
          cur_d    = fs_q;
          div_freq = fs_q;
          go       = 1'b1;
          state_d  = ST_DIVIDE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        if (div_rdy) begin
          cfg_freq_d  = cur_q;
          cfg_half_d  = halve(sat32(quotient));
          cfg_valid_d = 1'b1;
          state_d     = ST_PUBLISH;
        end
      end
      ST_PUBLISH: begin
        if (cfg_ack) begin
          cfg_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (tick_edge) begin
          if (cnt_inc >= dwell_tgt) state_d = ST_NEXT;
          else                      cnt_d   = cnt_inc[DWELL_W-1:0];
        end
      end
      ST_NEXT: begin
        // overshooting points are dropped, never published
        if (nxt > {1'b0, fe_q}) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cur_d    = nxt[11:0];
          div_freq = nxt[11:0];
          go       = 1'b1;
          state_d  = ST_DIVIDE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d     = ST_IDLE;
      cfg_valid_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      go          = 1'b0;
    end
    // a start that will be rejected never raises busy
    busy_d = (state_d != ST_IDLE);
    if (state_q == ST_IDLE && !cfg_legal(f_start, f_stop, f_inc)) busy_d = 1'b0;
  end

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cfg_valid_q <= 1'b0;
      cfg_freq_q  <= '0;
      cfg_half_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      tick_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_freq_q  <= cfg_freq_d;
      cfg_half_q  <= cfg_half_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      tick_prev_q <= tick_in;
    end
  end

  always_ff @(posedge CLOCK) begin
    fs_q   <= fs_d;
    fe_q   <= fe_d;
    fi_q   <= fi_d;
    step_q <= step_d;
    cur_q  <= cur_d;
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_freq  = cfg_freq_q;
  assign cfg_half  = cfg_half_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Randomized bench for sweep_ctrl against a point-list / handshake reference model.
module tb_sweep_ctrl;

  logic        CLOCK = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] f_start = '0, f_stop = '0, f_inc = '0;
  logic [7:0]  step = '0;
  logic [15:0] dwell = '0;
  logic        tick_in = 1'b0;
  logic        cfg_ack = 1'b0;
  logic        cfg_valid, busy, done, err;
  logic [11:0] cfg_freq;
  logic [31:0] cfg_half;

  int n_chk = 0;
  int n_pass = 0;

  sweep_ctrl #(.DWELL_W(16)) dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_inc(f_inc), .step(step), .dwell(dwell),
    .tick_in(tick_in), .cfg_valid(cfg_valid), .cfg_ack(cfg_ack),
    .cfg_freq(cfg_freq), .cfg_half(cfg_half), .busy(busy), .done(done), .err(err)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic longint half_ref(input int f, input int st);
    longint q;
    q = (longint'(100_000_000) * st) / (longint'(f) * 8192);
    if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
    return q / 2;
  endfunction

  // hold < 0: random ack delay per point; abort_mid: abort a few cycles into the first dwell
  task automatic run_sweep(input int fs, input int fe, input int fi, input int st,
                           input int dw, input int hold, input bit abort_mid);
    int ef[$];
    longint eh[$];
    int n, due, idx, phase, waited, ecnt, mark, h, tgt, dcyc;
    bit newt;
    for (int f = fs; f <= fe; f += fi) begin
      ef.push_back(f);
      eh.push_back(half_ref(f, st));
    end
    f_start = 12'(fs); f_stop = 12'(fe); f_inc = 12'(fi); step = 8'(st); dwell = 16'(dw);
    cfg_ack = (hold == 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 1;
    chk("busy_after_start", busy, 1);
    f_start = 12'($urandom_range(0, 4095));
    f_stop  = 12'($urandom_range(0, 4095));
    f_inc   = 12'($urandom_range(0, 4095));
    step    = 8'($urandom_range(0, 255));
    due = 38; idx = 0; phase = 0; waited = 0; ecnt = 0; mark = 0; dcyc = 0;
    tgt = (dw == 0) ? 1 : dw;
    h = (hold < 0) ? $urandom_range(0, 4) : hold;
    while (phase < 4 && n < 20000) begin
      if (phase != 3 && done) chk("spurious_done", done, 0);
      case (phase)
        0: begin
          if (cfg_valid) begin
            chk("valid_latency", n, due);
            chk("cfg_freq", cfg_freq, ef[idx]);
            chk("cfg_half", cfg_half, eh[idx]);
            waited = 0;
            phase = 1;
          end else if (n > due) begin
            chk("valid_timeout", n, due);
            phase = 4;
          end
        end
        1: begin
          if (cfg_ack) begin
            chk("valid_drop", cfg_valid, 0);
            phase = 2; ecnt = 0; dcyc = 0;
          end else begin
            chk("hold_valid", cfg_valid, 1);
            chk("hold_freq", cfg_freq, ef[idx]);
            chk("hold_half", cfg_half, eh[idx]);
            waited++;
          end
        end
        3: begin
          if (n == mark + 2) begin
            if (idx == ef.size() - 1) begin
              chk("done_pulse", done, 1);
              chk("busy_at_end", busy, 0);
              chk("point_count", idx + 1, ef.size());
              phase = 4;
            end else begin
              chk("done_early", done, 0);
              idx++;
              due = mark + 38;
              h = (hold < 0) ? $urandom_range(0, 4) : hold;
              phase = 0;
            end
          end
        end
        default: ;
      endcase
      if (phase < 4) begin
        start = 1'b0;
        if (phase == 1) cfg_ack = (waited >= h);
        else cfg_ack = (hold == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        newt = ($urandom_range(0, 2) == 0);
        if (phase == 2) begin
          if (abort_mid && dcyc == 2) begin
            abort = 1'b1;
            tick_in = newt;
            cyc();
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_valid", cfg_valid, 0);
            chk("abort_done", done, 0);
            chk("abort_keeps_freq", cfg_freq, ef[0]);
            for (int i = 0; i < 6; i++) begin
              cyc();
              if (done || busy) chk("post_abort_idle", {done, busy}, 0);
            end
            phase = 5;
          end else begin
            if (dcyc == 0 && idx == 0) start = 1'b1;
            if (newt && !tick_in) ecnt++;
            if (ecnt == tgt) begin
              phase = 3;
              mark = n;
            end
            dcyc++;
          end
        end
        if (phase < 4) begin
          tick_in = newt;
          cyc();
          n++;
        end
      end
    end
    start = 1'b0;
    if (phase < 4) chk("sweep_timeout_cycles", n, 0);
  endtask

  task automatic run_illegal(input int fs, input int fe, input int fi);
    f_start = 12'(fs); f_stop = 12'(fe); f_inc = 12'(fi); step = 8'd1; dwell = 16'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("illegal_err_c1", err, 0);
    chk("illegal_busy_c1", busy, 0);
    cyc();
    chk("illegal_err_c2", err, 1);
    chk("illegal_busy_c2", busy, 0);
    chk("illegal_valid_c2", cfg_valid, 0);
    cyc();
    chk("illegal_err_c3", err, 0);
  endtask

  initial begin
    int fs, fi, fe, k, seen;
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", cfg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_freq", cfg_freq, 0);
    chk("rst_half", cfg_half, 0);
    reset_n = 1'b1;
    cyc();

    run_sweep(1000, 1000, 1, 1, 2, 0, 1'b0);
    chk("t1_half_value", cfg_half, 6);
    run_sweep(100, 130, 10, 8, 1, -1, 1'b0);
    run_sweep(100, 125, 10, 8, 1, -1, 1'b0);
    run_illegal(100, 3000, 10);
    run_illegal(100, 200, 0);
    run_illegal(200, 100, 10);
    run_illegal(0, 100, 10);
    run_sweep(2828, 2828, 5, 255, 0, 10, 1'b0);
    run_sweep(300, 400, 50, 3, 50, 0, 1'b1);
    run_sweep(700, 900, 100, 2, 1, 0, 1'b0);

    // start and abort together in IDLE
    f_start = 12'd500; f_stop = 12'd500; f_inc = 12'd1; step = 8'd1;
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      cyc();
      if (cfg_valid || busy) seen++;
    end
    chk("start_abort_idle", seen, 0);

    // reset mid-divide
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    tick_in = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", cfg_valid, 0);
    chk("rst_mid_freq", cfg_freq, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    run_sweep(1000, 1000, 1, 1, 2, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      fs = $urandom_range(1, 2000);
      fi = $urandom_range(1, 300);
      k  = $urandom_range(0, 3);
      fe = fs + fi * k + $urandom_range(0, fi - 1);
      if (fe > 2828) fe = 2828;
      run_sweep(fs, fe, fi, $urandom_range(1, 255), $urandom_range(0, 3), -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
